ld_hazard_ctrl: RTL and testbench

- Pipeline hazard controller upstream of the ID/EX register.
- Tracks loads in flight through EX and MEM and detects load-use dependencies for the instruction in decode.
- Drives the ID/EX register's stall_from_ld_2clk_i, stall_from_ld_1clk_i and flush inputs, plus PC and IF/ID hold.
- No memory forwarding in this core: load data is usable three cycles after the load leaves decode.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/ld_tracker.sv | 50 +++++
 rtl/ld_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_ld_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the load-use hazard controller (ld_hazard_ctrl).
// Holds the register address width, the stall FSM state type, the load tracker
// entry type and the source/destination match helper.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    S2B  = 1'b1
  } ld_fsm_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
  } trk_entry_t;

  localparam trk_entry_t TrkEmpty = '{valid: 1'b0, rd: '0};

  // True when a real decode instruction reads the register a tracked load writes.
  // x0 is hard-wired, so a load to x0 never creates a dependency.
  function automatic logic trk_match(input trk_entry_t        e,
                                     input logic              id_valid,
                                     input logic [REG_AW-1:0] rs1,
                                     input logic              rs1_used,
                                     input logic [REG_AW-1:0] rs2,
                                     input logic              rs2_used);
    logic hit;
    hit = (rs1_used && (rs1 == e.rd)) || (rs2_used && (rs2 == e.rd));
    return e.valid && id_valid && (e.rd != '0) && hit;
  endfunction

endpackage

// File: rtl/ld_tracker.sv
// ld_tracker: two-entry record of loads in flight through EX and MEM, plus the
// dependency check of the decode instruction against each entry.
module ld_tracker
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic              id_is_load_i,
  input  logic [REG_AW-1:0] id_rd_i,
  // Decode instruction actually advances into EX this cycle.
  input  logic              capture_en_i,
  output logic              hz_ex_o,
  output logic              hz_mem_o
);

  trk_entry_t trk_ex_q, trk_ex_d;
  trk_entry_t trk_mem_q, trk_mem_d;

  // Next-state: record a load leaving decode; anything else enters EX as empty.
  always_comb begin
    trk_ex_d  = TrkEmpty;
    trk_mem_d = trk_ex_q;
    if (id_valid_i && id_is_load_i && (id_rd_i != '0) && capture_en_i) begin
      trk_ex_d.valid = 1'b1;
      trk_ex_d.rd    = id_rd_i;
    end
  end

  // Shift the tracker every cycle, including stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_ex_q  <= TrkEmpty;
      trk_mem_q <= TrkEmpty;
    end else begin
      trk_ex_q  <= trk_ex_d;
      trk_mem_q <= trk_mem_d;
    end
  end

  assign hz_ex_o  = trk_match(trk_ex_q, id_valid_i, id_rs1_i, id_rs1_used_i,
                              id_rs2_i, id_rs2_used_i);
  assign hz_mem_o = trk_match(trk_mem_q, id_valid_i, id_rs1_i, id_rs1_used_i,
                              id_rs2_i, id_rs2_used_i);

endmodule

// File: rtl/ld_hazard_ctrl.sv
// ld_hazard_ctrl: load-use hazard controller ahead of the ID/EX register.
// Without memory forwarding, a consumer directly behind a load needs two bubbles
// and one two slots behind needs one. A taken branch in EX squashes and overrides.
// Optional performance counters are built when LD_HAZARD_PERF_CNT_EN is defined.
module ld_hazard_ctrl #(
  parameter int unsigned REG_AW = hazard_pkg::REG_AW,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic              id_is_load_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              ex_branch_taken_i,
  output logic              stall_from_ld_2clk_o,
  output logic              stall_from_ld_1clk_o,
  output logic              flush_o,
  output logic              pc_hold_o,
  output logic              ifid_hold_o
`ifdef LD_HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cyc_o,
  output logic [PERF_W-1:0] perf_ld_hz_o,
  output logic [PERF_W-1:0] perf_flush_o
`endif
);

  import hazard_pkg::ld_fsm_e;
  import hazard_pkg::IDLE;
  import hazard_pkg::S2B;

  logic    hz_ex, hz_mem;
  logic    flush;
  logic    stall_2clk, stall_1clk, any_stall;
  logic    capture_en;
  ld_fsm_e state_q;

  ld_tracker u_tracker (
    .clk          (clk),
    .rst          (rst),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_used_i(id_rs2_used_i),
    .id_is_load_i (id_is_load_i),
    .id_rd_i      (id_rd_i),
    .capture_en_i (capture_en),
    .hz_ex_o      (hz_ex),
    .hz_mem_o     (hz_mem)
  );

  // Gated by reset so every output is low while reset is held.
  assign flush = ex_branch_taken_i && !rst;

  // Stall decode: EX-distance load costs two bubbles (the second is S2B), MEM-distance
  // load one. In S2B the load sits in MEM, so hz_mem is absorbed there.
  always_comb begin
    stall_2clk = 1'b0;
    stall_1clk = 1'b0;
    if (!flush) begin
      case (state_q)
        IDLE: begin
          stall_2clk = hz_ex;
          stall_1clk = !hz_ex && hz_mem;
        end
        S2B: stall_2clk = 1'b1;
        default: stall_2clk = 1'b0;
      endcase
    end
  end

  assign any_stall  = stall_2clk || stall_1clk;
  assign capture_en = !any_stall && !flush;

  // Stall FSM: a flush always returns it to IDLE; S2B lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (hz_ex) state_q <= S2B;
        S2B:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_from_ld_2clk_o = stall_2clk;
  assign stall_from_ld_1clk_o = stall_1clk;
  assign flush_o              = flush;
  assign pc_hold_o            = any_stall;
  assign ifid_hold_o          = any_stall;

`ifdef LD_HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_cyc_q, perf_stall_cyc_d;
  logic [PERF_W-1:0] perf_ld_hz_q, perf_ld_hz_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
  logic              ld_hz_evt;

  // One event per hazard: the first cycle of a two-cycle stall or a one-cycle stall.
  assign ld_hz_evt = (stall_2clk && (state_q == IDLE)) || stall_1clk;

  // Counter increments; all wrap naturally at 2^PERF_W.
  always_comb begin
    perf_stall_cyc_d = perf_stall_cyc_q + PERF_W'(any_stall);
    perf_ld_hz_d     = perf_ld_hz_q + PERF_W'(ld_hz_evt);
    perf_flush_d     = perf_flush_q + PERF_W'(flush);
  end

  // Counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc_q <= '0;
      perf_ld_hz_q     <= '0;
      perf_flush_q     <= '0;
    end else begin
      perf_stall_cyc_q <= perf_stall_cyc_d;
      perf_ld_hz_q     <= perf_ld_hz_d;
      perf_flush_q     <= perf_flush_d;
    end
  end

  assign perf_stall_cyc_o = perf_stall_cyc_q;
  assign perf_ld_hz_o     = perf_ld_hz_q;
  assign perf_flush_o     = perf_flush_q;
`else
  logic unused_perf_w;
  assign unused_perf_w = (PERF_W != 0);
`endif

endmodule

// File: tb/tb_ld_hazard_ctrl.sv
// tb_ld_hazard_ctrl: directed load-use scenarios followed by random instruction
// streams, checked against a model that tracks when each load left decode.
module tb_ld_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_is_load, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_2clk, stall_1clk, flush, pc_hold, ifid_hold;
`ifdef LD_HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_ld_hz, perf_flush;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: loads that left decode, with the cycle they left.
  typedef struct {
    int rd;
    int cyc;
  } ld_rec_t;
  ld_rec_t ldq[$];
  int      cyc = 0;
  int      owed = 0;   // bubbles still owed to a two-cycle stall
  int      m_stall = 0, m_hz = 0, m_flush = 0;

  always #5 clk = ~clk;

  ld_hazard_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_valid_i          (id_valid),
    .id_rs1_i            (id_rs1),
    .id_rs2_i            (id_rs2),
    .id_rs1_used_i       (id_rs1_used),
    .id_rs2_used_i       (id_rs2_used),
    .id_is_load_i        (id_is_load),
    .id_rd_i             (id_rd),
    .ex_branch_taken_i   (ex_branch_taken),
    .stall_from_ld_2clk_o(stall_2clk),
    .stall_from_ld_1clk_o(stall_1clk),
    .flush_o             (flush),
    .pc_hold_o           (pc_hold),
    .ifid_hold_o         (ifid_hold)
`ifdef LD_HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cyc_o    (perf_stall_cyc),
    .perf_ld_hz_o        (perf_ld_hz),
    .perf_flush_o        (perf_flush)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Smallest age (1 or 2 cycles) of a load the decode instruction depends on; 0 if none.
  function automatic int load_dist(input logic [4:0] rs1, input logic u1,
                                   input logic [4:0] rs2, input logic u2);
    int best = 0;
    foreach (ldq[i]) begin
      int age = cyc - ldq[i].cyc;
      if (age >= 1 && age <= 2 &&
          ((u1 && int'(rs1) == ldq[i].rd) || (u2 && int'(rs2) == ldq[i].rd))) begin
        if (best == 0 || age < best) best = age;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    ldq.delete();
    owed    = 0;
    m_stall = 0;
    m_hz    = 0;
    m_flush = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_2clk"}, {31'd0, stall_2clk}, 32'd0);
    chk({tag, "_1clk"}, {31'd0, stall_1clk}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_pchold"}, {31'd0, pc_hold}, 32'd0);
    chk({tag, "_ifidhold"}, {31'd0, ifid_hold}, 32'd0);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_is_load = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_rs1_used = 0; id_rs2_used = 0; ex_branch_taken = 0;
  endtask

  // One decode cycle: drive at negedge, check the combinational outputs, advance model.
  task automatic step(input string tag, input logic v, input logic ld, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                      input logic u2, input logic br);
    int   d;
    logic e2, e1, evt;
    @(negedge clk);
    id_valid = v; id_is_load = ld; id_rd = rd; id_rs1 = rs1; id_rs1_used = u1;
    id_rs2 = rs2; id_rs2_used = u2; ex_branch_taken = br;
    #1;
    d = v ? load_dist(rs1, u1, rs2, u2) : 0;
    if (br) begin
      e2 = 0; e1 = 0;
    end else if (owed > 0) begin
      e2 = 1; e1 = 0;
    end else begin
      e2 = (d == 1); e1 = (d == 2);
    end
    chk({tag, "_2clk"}, {31'd0, stall_2clk}, {31'd0, e2});
    chk({tag, "_1clk"}, {31'd0, stall_1clk}, {31'd0, e1});
    chk({tag, "_flush"}, {31'd0, flush}, {31'd0, br});
    chk({tag, "_pchold"}, {31'd0, pc_hold}, {31'd0, e1 | e2});
    chk({tag, "_ifidhold"}, {31'd0, ifid_hold}, {31'd0, e1 | e2});
`ifdef LD_HAZARD_PERF_CNT_EN
    chk({tag, "_pstall"}, perf_stall_cyc, 32'(m_stall));
    chk({tag, "_phz"}, perf_ld_hz, 32'(m_hz));
    chk({tag, "_pflush"}, perf_flush, 32'(m_flush));
`endif
    evt = e1 || (e2 && owed == 0);
    m_stall += int'(e1 | e2);
    m_hz    += int'(evt);
    m_flush += int'(br);
    if (br) owed = 0;
    else if (owed > 0) owed--;
    else if (e2) owed = 1;
    if (v && ld && rd != 0 && !e1 && !e2 && !br) ldq.push_back('{int'(rd), cyc});
    cyc++;
    while (ldq.size() > 0 && cyc - ldq[0].cyc > 2) ldq.pop_front();
  endtask

  task automatic bubbles();
    step("gap", 0, 0, 0, 0, 0, 0, 0, 0);
    step("gap", 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // lw x5 then add x6,x5,x1: two-cycle stall.
    step("t1_lw", 1, 1, 5, 1, 1, 0, 0, 0);
    step("t1_c1", 1, 0, 6, 5, 1, 1, 1, 0);
    chk("t1_c1_2clk_k", {31'd0, stall_2clk}, 32'd1);
    step("t1_c2", 1, 0, 6, 5, 1, 1, 1, 0);
    chk("t1_c2_2clk_k", {31'd0, stall_2clk}, 32'd1);
    chk("t1_c2_1clk_k", {31'd0, stall_1clk}, 32'd0);
    step("t1_c3", 1, 0, 6, 5, 1, 1, 1, 0);
    chk("t1_c3_hold_k", {31'd0, pc_hold}, 32'd0);
`ifdef LD_HAZARD_PERF_CNT_EN
    chk("t1_pstall_k", perf_stall_cyc, 32'd2);
    chk("t1_phz_k", perf_ld_hz, 32'd1);
`endif
    bubbles();

    // lw x5, independent, add x5: one-cycle stall.
    step("t2_lw", 1, 1, 5, 1, 1, 0, 0, 0);
    step("t2_ind", 1, 0, 7, 2, 1, 3, 1, 0);
    step("t2_c1", 1, 0, 6, 1, 1, 5, 1, 0);
    chk("t2_c1_1clk_k", {31'd0, stall_1clk}, 32'd1);
    step("t2_c2", 1, 0, 6, 1, 1, 5, 1, 0);
    chk("t2_c2_hold_k", {31'd0, pc_hold}, 32'd0);
    bubbles();

    // lw x0 then reader of x0; unused rs2 naming x5.
    step("t3_lw0", 1, 1, 0, 1, 1, 0, 0, 0);
    step("t3_x0", 1, 0, 6, 0, 1, 0, 1, 0);
    chk("t3_x0_hold_k", {31'd0, pc_hold}, 32'd0);
    step("t3_lw5", 1, 1, 5, 1, 1, 0, 0, 0);
    step("t3_rs2unused", 1, 0, 6, 1, 1, 5, 0, 0);
    chk("t3_rs2_hold_k", {31'd0, pc_hold}, 32'd0);
    step("t3_invalid", 0, 0, 6, 5, 1, 5, 1, 0);
    chk("t3_inv_hold_k", {31'd0, pc_hold}, 32'd0);
    bubbles();

    // Flush in the second stall cycle.
    step("t4_lw", 1, 1, 5, 1, 1, 0, 0, 0);
    step("t4_c1", 1, 0, 6, 5, 1, 1, 1, 0);
    step("t4_c2", 1, 0, 6, 5, 1, 1, 1, 1);
    chk("t4_c2_flush_k", {31'd0, flush}, 32'd1);
    chk("t4_c2_2clk_k", {31'd0, stall_2clk}, 32'd0);
    step("t4_c3", 1, 0, 6, 5, 1, 1, 1, 0);
    chk("t4_c3_2clk_k", {31'd0, stall_2clk}, 32'd0);
    bubbles();

    // lw x5, lw x6, add x7,x5,x6: single two-cycle stall.
    step("t5_lw5", 1, 1, 5, 1, 1, 0, 0, 0);
    step("t5_lw6", 1, 1, 6, 1, 1, 0, 0, 0);
    step("t5_c1", 1, 0, 7, 5, 1, 6, 1, 0);
    chk("t5_c1_2clk_k", {31'd0, stall_2clk}, 32'd1);
    step("t5_c2", 1, 0, 7, 5, 1, 6, 1, 0);
    chk("t5_c2_2clk_k", {31'd0, stall_2clk}, 32'd1);
    step("t5_c3", 1, 0, 7, 5, 1, 6, 1, 0);
    chk("t5_c3_1clk_k", {31'd0, stall_1clk}, 32'd0);
    bubbles();

    // Reset pulsed during the second stall cycle.
    step("t6_lw", 1, 1, 5, 1, 1, 0, 0, 0);
    step("t6_c1", 1, 0, 6, 5, 1, 1, 1, 0);
    step("t6_c2", 1, 0, 6, 5, 1, 1, 1, 0);
    chk("t6_c2_2clk_k", {31'd0, stall_2clk}, 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    model_reset();
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("t6_after", 1, 0, 6, 5, 1, 1, 1, 0);
    chk("t6_after_hold_k", {31'd0, pc_hold}, 32'd0);

    // Random instruction stream over a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 40),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 10));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
